stock_price_table: RTL and testbench
====================================

Name: stock_price_table

Overview:
Parametrised successor to the fixed 512x49 stock-price RAM. Holds one price record per stock index and adds:
- a per-entry valid bit
- separate update and query ports with valid/ready handshakes
- write-first collision forwarding
- a hardware sweep that clears the table after reset or on a flush request

Sits in the output-port-lookup path: the feed parser drives updates; the order logic issues queries.

Parameters:
DATA_W, 49, price record width in bits
ADDR_W, 9, index width; DEPTH = 2**ADDR_W entries
INIT_ON_RESET, 1, 1 = run clear sweep after reset; 0 = start READY with RAM contents undefined (simulation only)

Ports:
axis_aclk  in  1  clock; all logic on rising edge
axis_resetn  in  1  synchronous reset, active low
flush_req  in  1  single-cycle pulse; starts a clear sweep
busy  out  1  high while a sweep runs
upd_valid  in  1  update request
upd_ready  out  1  update accepted when valid&ready
upd_addr  in  ADDR_W  stock index to write
upd_data  in  DATA_W  price record
qry_valid  in  1  query request
qry_ready  out  1  query accepted when valid&ready
qry_addr  in  ADDR_W  stock index to read
rsp_valid  out  1  response available
rsp_ready  in  1  downstream accepts response
rsp_hit  out  1  entry written since last sweep
rsp_data  out  DATA_W  stored record; all zero when rsp_hit=0

Behaviour:
- Storage: one simple-dual-port block RAM, DEPTH x (DATA_W+1); bit DATA_W is the valid bit. Write port and read port are independent in the same cycle.
- Reset (axis_resetn=0 at an edge) forces:
  - busy=1 if INIT_ON_RESET, else 0
  - upd_ready=0, qry_ready=0
  - rsp_valid=0, rsp_hit=0, rsp_data=0
  - sweep counter=0
  - in-flight query dropped
- FSM states:
  - INIT: write {valid=0, data=0} at sweep counter, increment each cycle. After writing DEPTH-1, go to READY on the next edge. Sweep takes exactly DEPTH cycles with busy=1.
  - READY: busy=0. flush_req=1 -> INIT with counter cleared. An update accepted in the same cycle as flush_req is still written; the sweep then clears it.
  - In INIT: upd_ready=0 and qry_ready=0. A response already held in rsp_* stays until taken.
  - flush_req during INIT restarts the counter at 0.
- Update path:
  - upd_ready=1 in READY.
  - Accepted update writes {1, upd_data} at upd_addr on that edge.
  - No output response.
- Query path:
  - qry_ready = READY & (~rsp_valid | rsp_ready).
  - Query accepted at edge k: rsp_valid=1 and rsp_hit/rsp_data valid after edge k+1 (latency 2: RAM register, then response register).
  - rsp_* hold stable while rsp_valid & ~rsp_ready.
  - Back-to-back queries each cycle give full throughput when rsp_ready=1.
  - rsp_valid drops the edge after the handshake if no new result follows.
- Collision: an update and a query to the same address accepted in the same cycle return the new data with hit=1 (write-first forwarding). An update landing in the cycle between query accept and response is not forwarded; the response carries the old data.
- Miss: rsp_hit=0 forces rsp_data=0, regardless of RAM contents.
- Reset mid-sweep: the sweep restarts from 0.

Optional Feature:
Macro STOCK_PRICE_PARITY_EN.
- Defined:
  - RAM width becomes DATA_W+2; an even-parity bit over {valid,data} is stored on every write, sweep included.
  - Extra output rsp_perr (1 bit, reset 0), qualified by rsp_valid, asserted when recomputed parity mismatches.
  - Data is still returned unmodified.
- Undefined: no parity bit, no rsp_perr port.

Decomposition:
- Package stock_price_pkg:
  - state enum {ST_INIT, ST_READY}
  - function for the RAM entry width
  - parity helper function
- Sub-module stock_price_sdp_ram:
  - parametrised simple-dual-port RAM, block-RAM attribute
  - registered read with enable, so the RAM output holds during stall
  - forwarding mux lives in the parent

Test Plan:
- Reset with INIT_ON_RESET=1, DEPTH=512 -> busy=1 for exactly 512 cycles; upd_ready/qry_ready=0 throughout; then busy=0 and both ready=1.
- After sweep, query addr 0x1A5 -> rsp_valid 2 cycles later, rsp_hit=0, rsp_data=0.
- Update addr 0x003 data 0x1_2345_6789_ABCD, then query 0x003 -> rsp_hit=1, rsp_data=0x1_2345_6789_ABCD.
- Same-cycle update 0x010=0x55 and query 0x010 (previous value 0x22) -> response 0x55, hit=1. Update issued one cycle after the query -> response 0x22.
- Queries to 0x001..0x004 back-to-back with rsp_ready low for cycles 3-5 -> no response lost or duplicated, rsp_* stable while stalled, qry_ready low during stall.
- flush_req after writing 0x0FF, then query 0x0FF after busy falls -> hit=0. Drive axis_resetn=0 mid-sweep -> busy holds 1 and sweep lasts a full 512 cycles after release.

Source files
------------

// File: rtl/stock_price_pkg.sv
// Shared types and helpers for the stock price table.
// Optional feature macro: STOCK_PRICE_PARITY_EN (adds a stored even-parity bit).
package stock_price_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Widest {valid,data} word the parity helper accepts.
    localparam int unsigned PAR_MAX_W = 1024;

    // RAM entry width: {valid, data}, plus a parity bit when enabled.
    function automatic int unsigned entry_w(input int unsigned data_w);
`ifdef STOCK_PRICE_PARITY_EN
        return data_w + 2;
`else
        return data_w + 1;
`endif
    endfunction

    // Even-parity bit; zero-extension of the argument does not change it.
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/stock_price_sdp_ram.sv
// Simple-dual-port block RAM with an enabled, registered read port.
module stock_price_sdp_ram #(
    parameter int unsigned WIDTH  = 50,
    parameter int unsigned ADDR_W = 9
) (
    input  logic              clk_a,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    (* ram_style = "block" *) logic [WIDTH-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clk_a) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read port; output holds while rd_en is low so a stalled result survives.
    always_ff @(posedge clk_a) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/stock_price_table.sv
// Stock price table: per-index price record with valid bit, update/query
// handshakes, write-first collision forwarding and a hardware clear sweep.
// Optional feature macro: STOCK_PRICE_PARITY_EN (stored parity, rsp_perr output).
module stock_price_table
    import stock_price_pkg::*;
#(
    parameter int unsigned DATA_W        = 49,
    parameter int unsigned ADDR_W        = 9,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic              axis_aclk,
    input  logic              axis_resetn,
    input  logic              flush_req,
    output logic              busy,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [ADDR_W-1:0] upd_addr,
    input  logic [DATA_W-1:0] upd_data,
    input  logic              qry_valid,
    output logic              qry_ready,
    input  logic [ADDR_W-1:0] qry_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_hit,
    output logic [DATA_W-1:0] rsp_data
`ifdef STOCK_PRICE_PARITY_EN
    ,
    output logic              rsp_perr
`endif
);

    localparam int unsigned ENTRY_W = entry_w(DATA_W);
    localparam int unsigned PAY_W   = DATA_W + 1;

    state_t              state;
    logic [ADDR_W-1:0]   sweep_cnt;
    logic                rdy_q;

    logic                adv_c;
    logic                upd_fire_c;
    logic                qry_fire_c;
    logic                fwd_c;

    logic                wr_en_c;
    logic [ADDR_W-1:0]   wr_addr_c;
    logic [PAY_W-1:0]    wr_payload_c;
    logic [ENTRY_W-1:0]  wr_word_c;

    logic [ENTRY_W-1:0]  ram_q;
    logic                s1_valid;
    logic                s1_fwd;
    logic [ENTRY_W-1:0]  s1_fwd_word;
    logic [ENTRY_W-1:0]  rd_entry_c;
    logic                hit_c;

    // Handshake qualifiers; the response slot frees when empty or being taken.
    assign upd_ready  = rdy_q;
    assign adv_c      = ~rsp_valid | rsp_ready;
    assign qry_ready  = rdy_q & adv_c;
    assign upd_fire_c = upd_valid & rdy_q;
    assign qry_fire_c = qry_valid & qry_ready;
    assign fwd_c      = upd_fire_c & qry_fire_c & (upd_addr == qry_addr);

    // Write-port source: sweep clears while in INIT, updates otherwise.
    always_comb begin
        wr_en_c      = 1'b0;
        wr_addr_c    = upd_addr;
        wr_payload_c = {1'b1, upd_data};
        if (state == ST_INIT) begin
            wr_en_c      = axis_resetn;
            wr_addr_c    = sweep_cnt;
            wr_payload_c = '0;
        end else begin
            wr_en_c      = axis_resetn & upd_fire_c;
        end
`ifdef STOCK_PRICE_PARITY_EN
        wr_word_c = {even_parity(PAR_MAX_W'(wr_payload_c)), wr_payload_c};
`else
        wr_word_c = wr_payload_c;
`endif
    end

    stock_price_sdp_ram #(
        .WIDTH  (ENTRY_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_a   (axis_aclk),
        .wr_en   (wr_en_c),
        .wr_addr (wr_addr_c),
        .wr_data (wr_word_c),
        .rd_en   (qry_fire_c),
        .rd_addr (qry_addr),
        .rd_data (ram_q)
    );

    // Read result: forwarded update word on a same-cycle collision, else RAM.
    assign rd_entry_c = s1_fwd ? s1_fwd_word : ram_q;
    assign hit_c      = rd_entry_c[DATA_W];

    // Sweep FSM, ready flag and the two-stage query pipeline.
    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            state       <= INIT_ON_RESET ? ST_INIT : ST_READY;
            busy        <= INIT_ON_RESET;
            rdy_q       <= 1'b0;
            sweep_cnt   <= '0;
            s1_valid    <= 1'b0;
            s1_fwd      <= 1'b0;
            s1_fwd_word <= '0;
            rsp_valid   <= 1'b0;
            rsp_hit     <= 1'b0;
            rsp_data    <= '0;
`ifdef STOCK_PRICE_PARITY_EN
            rsp_perr    <= 1'b0;
`endif
        end else begin
            case (state)
                ST_INIT: begin
                    if (flush_req) begin
                        sweep_cnt <= '0;
                    end else if (sweep_cnt == '1) begin
                        state     <= ST_READY;
                        busy      <= 1'b0;
                        rdy_q     <= 1'b1;
                        sweep_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    rdy_q <= 1'b1;
                    if (flush_req) begin
                        state     <= ST_INIT;
                        busy      <= 1'b1;
                        rdy_q     <= 1'b0;
                        sweep_cnt <= '0;
                    end
                end
            endcase

            if (adv_c) begin
                s1_valid  <= qry_fire_c;
                s1_fwd    <= fwd_c;
                if (fwd_c) begin
                    s1_fwd_word <= wr_word_c;
                end
                rsp_valid <= s1_valid;
                if (s1_valid) begin
                    rsp_hit  <= hit_c;
                    rsp_data <= hit_c ? rd_entry_c[DATA_W-1:0] : '0;
`ifdef STOCK_PRICE_PARITY_EN
                    rsp_perr <= ^rd_entry_c;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_stock_price_table.sv
// Directed self-checking bench for stock_price_table (default parameters).
module tb_stock_price_table;

    localparam int unsigned DATA_W = 49;
    localparam int unsigned ADDR_W = 9;

    logic              clk;
    logic              resetn;
    logic              flush_req;
    logic              busy;
    logic              upd_valid;
    logic              upd_ready;
    logic [ADDR_W-1:0] upd_addr;
    logic [DATA_W-1:0] upd_data;
    logic              qry_valid;
    logic              qry_ready;
    logic [ADDR_W-1:0] qry_addr;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_hit;
    logic [DATA_W-1:0] rsp_data;
`ifdef STOCK_PRICE_PARITY_EN
    logic              rsp_perr;
`endif

    int n_checks = 0;
    int n_errors = 0;

    stock_price_table dut (
        .axis_aclk   (clk),
        .axis_resetn (resetn),
        .flush_req   (flush_req),
        .busy        (busy),
        .upd_valid   (upd_valid),
        .upd_ready   (upd_ready),
        .upd_addr    (upd_addr),
        .upd_data    (upd_data),
        .qry_valid   (qry_valid),
        .qry_ready   (qry_ready),
        .qry_addr    (qry_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_hit     (rsp_hit),
        .rsp_data    (rsp_data)
`ifdef STOCK_PRICE_PARITY_EN
        ,
        .rsp_perr    (rsp_perr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Counts negedges with busy high, starting at the current negedge.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 2000) begin
            if (upd_ready !== 1'b0 || qry_ready !== 1'b0) begin
                check("ready_in_sweep", {upd_ready, qry_ready}, 0);
            end
            cnt++;
            @(negedge clk);
        end
    endtask

    // Single write; called and returns at a negedge.
    task automatic update(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        upd_valid = 1'b1;
        upd_addr  = a;
        upd_data  = d;
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    // Single query with rsp_ready high; checks 2-cycle latency and payload.
    task automatic query_expect(input string tag, input logic [ADDR_W-1:0] a,
                                input logic exp_hit, input logic [DATA_W-1:0] exp_data);
        qry_valid = 1'b1;
        qry_addr  = a;
        #1;
        check({tag, "_qry_ready"}, qry_ready, 1);
        @(negedge clk);
        qry_valid = 1'b0;
        check({tag, "_lat1"}, rsp_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, rsp_valid, 1);
        check({tag, "_hit"}, rsp_hit, exp_hit);
        check({tag, "_data"}, rsp_data, exp_data);
`ifdef STOCK_PRICE_PARITY_EN
        check({tag, "_perr"}, rsp_perr, 0);
`endif
    endtask

    initial begin
        int cnt;
        int q_idx;
        int n_resp;
        logic prev_stall;
        logic [DATA_W-1:0] prev_data;

        resetn    = 1'b0;
        flush_req = 1'b0;
        upd_valid = 1'b0;
        upd_addr  = '0;
        upd_data  = '0;
        qry_valid = 1'b0;
        qry_addr  = '0;
        rsp_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1);
        check("rst_upd_ready", upd_ready, 0);
        check("rst_qry_ready", qry_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_hit", rsp_hit, 0);
        check("rst_rsp_data", rsp_data, 0);

        // Initial sweep length.
        resetn = 1'b1;
        count_busy(cnt);
        check("init_sweep_len", cnt, 512);
        check("post_sweep_upd_ready", upd_ready, 1);
        check("post_sweep_qry_ready", qry_ready, 1);

        // Miss after sweep.
        query_expect("miss_1a5", 9'h1A5, 1'b0, '0);

        // Update then hit.
        update(9'h003, 49'h1_2345_6789_ABCD);
        query_expect("hit_003", 9'h003, 1'b1, 49'h1_2345_6789_ABCD);

        // Same-cycle collision forwards the new data.
        update(9'h010, 49'h22);
        upd_valid = 1'b1;
        upd_addr  = 9'h010;
        upd_data  = 49'h55;
        qry_valid = 1'b1;
        qry_addr  = 9'h010;
        @(negedge clk);
        upd_valid = 1'b0;
        qry_valid = 1'b0;
        check("coll_lat1", rsp_valid, 0);
        @(negedge clk);
        check("coll_valid", rsp_valid, 1);
        check("coll_hit", rsp_hit, 1);
        check("coll_data", rsp_data, 49'h55);

        // Update one cycle after the query is not forwarded.
        update(9'h010, 49'h22);
        qry_valid = 1'b1;
        qry_addr  = 9'h010;
        @(negedge clk);
        qry_valid = 1'b0;
        upd_valid = 1'b1;
        upd_addr  = 9'h010;
        upd_data  = 49'h55;
        @(negedge clk);
        upd_valid = 1'b0;
        check("late_upd_valid", rsp_valid, 1);
        check("late_upd_data", rsp_data, 49'h22);
        query_expect("late_upd_landed", 9'h010, 1'b1, 49'h55);

        // Back-to-back queries with a 3-cycle response stall.
        for (int i = 1; i <= 4; i++) begin
            update(9'(i), 49'(32'h100 + 32'(i)));
        end
        @(negedge clk);
        q_idx      = 0;
        n_resp     = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 16; c++) begin
            rsp_ready = !(c >= 3 && c <= 5);
            if (q_idx < 4) begin
                qry_valid = 1'b1;
                qry_addr  = 9'(q_idx + 1);
            end else begin
                qry_valid = 1'b0;
            end
            #1;
            if (prev_stall) begin
                check("stall_valid", rsp_valid, 1);
                check("stall_data", rsp_data, prev_data);
            end
            if (rsp_valid && !rsp_ready) begin
                check("stall_qry_ready", qry_ready, 0);
            end
            if (rsp_valid && rsp_ready) begin
                check("stream_hit", rsp_hit, 1);
                check("stream_data", rsp_data, 64'h101 + 64'(n_resp));
                n_resp++;
            end
            prev_stall = rsp_valid && !rsp_ready;
            prev_data  = rsp_data;
            if (qry_valid && qry_ready) q_idx++;
            @(negedge clk);
        end
        qry_valid = 1'b0;
        rsp_ready = 1'b1;
        check("stream_count", n_resp, 4);
        check("stream_idle", rsp_valid, 0);

        // Flush clears written entries.
        update(9'h0FF, 49'h77);
        query_expect("pre_flush_0ff", 9'h0FF, 1'b1, 49'h77);
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        count_busy(cnt);
        check("flush_sweep_len", cnt, 512);
        query_expect("post_flush_0ff", 9'h0FF, 1'b0, '0);
        query_expect("post_flush_003", 9'h003, 1'b0, '0);

        // Reset in the middle of a sweep restarts it.
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        repeat (100) @(negedge clk);
        resetn = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("midrst_busy", busy, 1);
            check("midrst_upd_ready", upd_ready, 0);
        end
        resetn = 1'b1;
        count_busy(cnt);
        check("midrst_sweep_len", cnt, 512);
        check("midrst_upd_ready_after", upd_ready, 1);
        query_expect("midrst_miss", 9'h004, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
